// File: rtl/memory_stage.sv
// memory_stage: EX/MEM + MEM/WB pipeline registers with a stalling req/ready data-memory handshake.
module memory_stage #(
  parameter int WIDTH   = 24,
  parameter int REGADDR = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   ALUResultE,
  input  logic [WIDTH-1:0]   writeDataE,
  input  logic [REGADDR-1:0] WA3E,
  input  logic               RegWriteE,
  input  logic               MemWriteE,
  input  logic               MemToRegE,
  output logic               memReq,
  output logic               memWe,
  output logic [WIDTH-1:0]   memAddr,
  output logic [WIDTH-1:0]   memWData,
  input  logic [WIDTH-1:0]   memRData,
  input  logic               memReady,
  output logic               stallM,
  output logic [WIDTH-1:0]   forwardM,
  output logic [REGADDR-1:0] WA3M,
  output logic               RegWriteM,
  output logic [WIDTH-1:0]   forwardWB,
  output logic [REGADDR-1:0] WA3W,
  output logic               RegWriteW,
  output logic               memError
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] wd_m;
  logic mw_m, mtr_m, timeout, load_m;
  logic [CW-1:0] cnt;
  assign timeout  = state == WAIT && cnt == CW'(TIMEOUT - 1) && !memReady;
  assign stallM   = state == WAIT && !memReady && !timeout;
  assign load_m   = mtr_m && !mw_m;
  assign memAddr  = forwardM;
  assign memWData = wd_m;
  // A completing access captures the next instruction, so a memory op there keeps us in WAIT.
  always_comb begin
    state_n = stallM ? WAIT : ((MemWriteE || MemToRegE) ? WAIT : IDLE);
    memReq  = state == WAIT;
    memWe   = state == WAIT && mw_m;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      memError  <= 1'b0;
      forwardM  <= '0;
      wd_m      <= '0;
      WA3M      <= '0;
      RegWriteM <= 1'b0;
      mw_m      <= 1'b0;
      mtr_m     <= 1'b0;
      forwardWB <= '0;
      WA3W      <= '0;
      RegWriteW <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= stallM ? cnt + CW'(1) : '0;
      memError <= memError || timeout;
      if (stallM) begin
        RegWriteW <= 1'b0;
      end else begin
        forwardM  <= ALUResultE;
        wd_m      <= writeDataE;
        WA3M      <= WA3E;
        RegWriteM <= RegWriteE;
        mw_m      <= MemWriteE;
        mtr_m     <= MemToRegE;
        RegWriteW <= RegWriteM && !mw_m;
        WA3W      <= WA3M;
        forwardWB <= load_m ? (timeout ? '0 : memRData) : forwardM;
      end
    end
  end
endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline memory stage of the 24-bit processor. Sits directly downstream of the execute stage and consumes its ALU result and forwarded store data. Holds the EX/MEM and MEM/WB pipeline registers and runs a req/ready handshake to data memory. Asserts a stall while an access is outstanding, and supplies the M-stage and WB-stage forwarding values back to execute.

## Interface
- WIDTH, 24, data/address width
- REGADDR, 4, destination register address width
- TIMEOUT, 15, maximum wait cycles per access before forced completion (≥1)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ALUResultE  in  WIDTH  ALU result from execute (address for memory ops)
- writeDataE  in  WIDTH  store data (forwarded operand 2 from execute)
- WA3E  in  REGADDR  destination register
- RegWriteE, MemWriteE, MemToRegE  in  1 each  control bits of the E-stage instruction
- memReq  out  1  access request to data memory
- memWe  out  1  1 = store, 0 = load
- memAddr  out  WIDTH  access address
- memWData  out  WIDTH  store data
- memRData  in  WIDTH  load data, valid when memReady=1
- memReady  in  1  access completes this cycle
- stallM  out  1  hold IF/ID/EX and their pipeline registers
- forwardM  out  WIDTH  ALU result of the M-stage instruction
- WA3M, RegWriteM  out  REGADDR/1  M-stage destination/write enable (for hazard unit)
- forwardWB  out  WIDTH  WB result (load data or ALU result)
- WA3W, RegWriteW  out  REGADDR/1  register-file write port controls
- memError  out  1  sticky: an access hit TIMEOUT

## Operation
- EX/MEM register: on each edge with stallM=0, captures ALUResultE, writeDataE, WA3E, RegWriteE, MemWriteE, MemToRegE. With stallM=1, it holds.
- Memory op: an M-stage instruction with MemWriteM=1 or MemToRegM=1. If both are set, it is treated as a store.
- FSM states: IDLE and WAIT.
  - IDLE → WAIT: on an edge where EX/MEM captures a memory op.
  - WAIT → IDLE: on completion (memReady=1 or timeout) when the newly captured instruction is not a memory op.
  - WAIT → WAIT: on completion when the newly captured instruction is a memory op (back-to-back).
- In WAIT:
  - memReq=1; memWe, memAddr=forwardM, memWData follow the EX/MEM register.
  - In IDLE, memReq=0 and memWe=0.
- stallM = (state==WAIT) && !memReady && !timeout. It is combinational, so it is deasserted in the completion cycle.
- Wait counter:
  - Clears on entry to WAIT.
  - Increments each WAIT cycle with memReady=0.
  - timeout = (count == TIMEOUT-1) && !memReady.
  - On timeout: access completes, load data forced to 0, memError set (sticky until rst).
- MEM/WB register, updated every edge:
  - Completing or non-memory instruction (stallM=0): RegWriteW←RegWriteM, WA3W←WA3M. forwardWB←memRData (load) or 0 (load timeout) or ALUResultM (otherwise).
  - While stallM=1: bubble inserted, RegWriteW←0, WA3W and forwardWB hold.
- Stores update no register regardless of RegWriteM.

## Timing
- Reset (rst high at an edge):
  - State IDLE, counter 0, memError 0.
  - All EX/MEM and MEM/WB fields 0, so every registered output is 0.
  - memReq=0 and stallM=0 the following cycle.
  - An outstanding access is abandoned without completion; memory must tolerate memReq dropping.
- Non-memory instruction: E in cycle t, M in t+1, WB in t+2, no stall.
- Load/store in M from cycle t+1 with memReady first high in cycle t+1+k:
  - stallM high for k cycles (t+1 … t+k).
  - WB valid at cycle t+2+k.
  - k=0 gives zero stall.
- Timeout: completion in the TIMEOUT-th WAIT cycle, i.e. at most TIMEOUT-1 stall cycles.
- memReady while IDLE is ignored.
- memRData is sampled only in the completion cycle.

## Test plan
- Reset: drive garbage inputs, rst=1 for 2 cycles → all outputs 0, memReq=0, stallM=0, memError=0.
- ALU pass-through: ALUResultE=0x00ABCD, WA3E=3, RegWriteE=1 at t → forwardM=0x00ABCD in t+1; forwardWB=0x00ABCD, WA3W=3, RegWriteW=1 in t+2; memReq never asserted.
- Load, zero wait: MemToRegE=1, addr 0x000010, memReady=1 at once, memRData=0x123456 → stallM never high, forwardWB=0x123456 at t+2.
- Load, 3 wait states: memReady high only in the 4th WAIT cycle → stallM high exactly 3 cycles, RegWriteW=0 during the bubbles, data written at t+5, EX/MEM inputs held.
- Back-to-back: store (addr 0x20, data 0x0000FF) followed by a load, memReady=1 each cycle → memWe=1 then 0 on consecutive cycles, no stall, store produces RegWriteW=0.
- Timeout plus reset mid-wait:
  - TIMEOUT=4 with memReady held 0 → stallM for 3 cycles, forwardWB=0, memError=1 and stays set.
  - Separately, rst during WAIT → memReq=0 and state IDLE in the next cycle.
